core_bus_arbiter: RTL and testbench
===================================

// Module: core_bus_arbiter
// PURPOSE
//  N-channel request arbiter between the core's bus channels (fetch, mem, ...) and a single
//  downstream bus port. Latches one-cycle request pulses per channel, grants round-robin,
//  issues one downstream transaction at a time and routes the response pulse back.
//  Sits between the core wrapper and the memory/MMU bus. Generalises the fixed fetch/mem pair.
// PARAMETERS
//  N_CH     2     number of requester channels (>=1); channel 0 = fetch, 1 = mem by convention
//  ADDR_W   32    address width
//  DATA_W   32    data width; strobe width is DATA_W/8
//  TIMEOUT  1024  downstream response watchdog limit in cycles (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk                   in   1             clock
//  rstn                  in   1             asynchronous active-low reset
//  req_enable            in   N_CH          per-channel one-cycle request pulse
//  req_mode              in   N_CH          1 = write, 0 = read
//  req_addr              in   N_CH*ADDR_W   flattened, channel i at [i*ADDR_W +: ADDR_W]
//  req_wdata             in   N_CH*DATA_W   flattened write data
//  req_wstrb             in   N_CH*DATA_W/8 flattened byte strobes
//  resp_enable           out  N_CH          per-channel one-cycle response pulse
//  resp_data             out  DATA_W        response data, valid with any resp_enable bit
//  resp_err              out  1             response is a timeout error (0 without BUS_TIMEOUT_EN)
//  out_request_enable    out  1             downstream one-cycle request pulse
//  out_mode/addr/wdata/wstrb out 1/ADDR_W/DATA_W/DATA_W/8  downstream request fields
//  out_response_enable   in   1             downstream one-cycle response pulse
//  out_resp_data         in   DATA_W        downstream response data
//  overrun               out  N_CH          sticky: request pulse received while channel pending
// BEHAVIOUR
//  - Reset: all outputs 0, pending[] 0, rr pointer 0, state IDLE, watchdog 0.
//  - Latch: on req_enable[i] with pending[i]==0, capture mode/addr/wdata/wstrb, set pending[i].
//    If pending[i]==1 the pulse is dropped, captured fields unchanged, overrun[i] set (sticky
//    until reset).
//  - FSM IDLE: if any pending, pick first pending channel at or after rr pointer (wrap at N_CH),
//    register grant g and out_* fields -> ISSUE. No pending -> stay.
//  - ISSUE: out_request_enable=1 for exactly this one cycle -> WAIT. out_mode/addr/wdata/wstrb
//    held stable from ISSUE until the response is accepted.
//  - WAIT: on out_response_enable: resp_data<=out_resp_data, resp_enable[g]<=1 next cycle
//    (one cycle), pending[g]<=0, rr pointer<=(g+1) mod N_CH -> IDLE.
//  - Latency: req pulse cycle t -> pending visible t+1 -> out_request_enable at t+2 (idle bus).
//    Downstream response cycle r -> resp_enable at r+1. Channel may re-request from r+1.
//  - out_response_enable in IDLE or ISSUE is ignored (downstream responds >=1 cycle after request).
//  - Same-cycle events: a new pulse on channel g in the cycle its downstream response arrives is
//    an overrun (pending still 1). Pulses on other channels latch normally in any state.
//  - Fairness: with all channels continuously pending, grants cycle 0,1,..,N_CH-1,0,...
//  - Reset mid-transaction: everything returns to reset values; an outstanding downstream
//    response arriving after rstn deasserts finds IDLE and is ignored.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: watchdog counts cycles in WAIT; on reaching TIMEOUT with no response,
//    resp_enable[g]=1, resp_err=1, resp_data=32'hDEADBEEF (zero-extended/truncated to DATA_W),
//    pending[g] cleared, pointer advanced, -> IDLE. A late response then is ignored.
//  Not defined: no watchdog, WAIT waits indefinitely, resp_err tied 0.
// STRUCTURE
//  Package core_bus_pkg: arbiter state enum (IDLE, ISSUE, WAIT), BUS_MODE_READ/WRITE constants,
//    TIMEOUT_DATA constant 32'hDEADBEEF.
//  Sub-module rr_pick: combinational round-robin picker (pending vector, pointer -> valid, index).
// TESTING
//  1. Single read ch0 addr 32'h1000, downstream responds 3 cycles later with 32'hCAFE0001 ->
//     out_request_enable 2 cycles after pulse, resp_enable=2'b01, resp_data=32'hCAFE0001.
//  2. ch0 and ch1 pulse same cycle after reset -> ch0 issued first, then ch1; ch1 write
//     carries mode=1, wstrb=4'b0011 unchanged to out_*.
//  3. N_CH=4, all channels re-request immediately after each response for 12 grants ->
//     grant order 0,1,2,3 repeated three times.
//  4. ch1 pulses twice while pending (addr 32'h20 then 32'h24) -> only 32'h20 issued,
//     overrun=2'b10 and stays set.
//  5. BUS_TIMEOUT_EN, TIMEOUT=16, no downstream response -> resp_enable pulse 16 cycles into
//     WAIT, resp_err=1, resp_data=32'hDEADBEEF; late response ignored.
//  6. rstn low during WAIT then high, downstream responds afterwards -> no resp_enable, all
//     outputs 0, next request issues normally.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core bus arbiter: FSM state encoding,
// bus mode values and the data word returned on a watchdog timeout.
package core_bus_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_e;

   localparam logic BUS_MODE_READ  = 1'b0;
   localparam logic BUS_MODE_WRITE = 1'b1;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set bit of 'pending'
// at or after 'ptr', wrapping at N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] index
);

   // Scan from the farthest candidate back to ptr so the nearest hit wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (pending[(int'(ptr) + k) % N]) begin
            valid = 1'b1;
            index = IW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/core_bus_arbiter.sv
// N-channel round-robin arbiter from per-channel request pulses onto one
// downstream bus port. Optional response watchdog: define BUS_TIMEOUT_EN.
module core_bus_arbiter
   import core_bus_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [N_CH-1:0]          req_enable,
   input  logic [N_CH-1:0]          req_mode,
   input  logic [N_CH*ADDR_W-1:0]   req_addr,
   input  logic [N_CH*DATA_W-1:0]   req_wdata,
   input  logic [N_CH*DATA_W/8-1:0] req_wstrb,
   output logic [N_CH-1:0]          resp_enable,
   output logic [DATA_W-1:0]        resp_data,
   output logic                     resp_err,
   output logic                     out_request_enable,
   output logic                     out_mode,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_wdata,
   output logic [DATA_W/8-1:0]      out_wstrb,
   input  logic                     out_response_enable,
   input  logic [DATA_W-1:0]        out_resp_data,
   output logic [N_CH-1:0]          overrun,
   output logic [1:0]               dbg_state
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

   // Handshake: every request/response is a single-cycle enable pulse with no
   // back-pressure; a channel owns at most one transaction until its response.
   logic [N_CH-1:0]        pending_q, pending_d;
   logic [N_CH-1:0]        overrun_q, overrun_d;
   logic [N_CH-1:0]        cap_mode_q, cap_mode_d;
   logic [N_CH*ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic [N_CH*DATA_W-1:0] cap_wdata_q, cap_wdata_d;
   logic [N_CH*STRB_W-1:0] cap_wstrb_q, cap_wstrb_d;

   arb_state_e             state_q, state_d;
   logic [CH_W-1:0]        grant_q, grant_d;
   logic [CH_W-1:0]        rr_q, rr_d;
   logic                   out_mode_q, out_mode_d;
   logic [ADDR_W-1:0]      out_addr_q, out_addr_d;
   logic [DATA_W-1:0]      out_wdata_q, out_wdata_d;
   logic [STRB_W-1:0]      out_wstrb_q, out_wstrb_d;
   logic [N_CH-1:0]        resp_enable_q, resp_enable_d;
   logic [DATA_W-1:0]      resp_data_q, resp_data_d;
   logic                   complete;

   logic                   pick_valid;
   logic [CH_W-1:0]        pick_idx;

`ifdef BUS_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic                   resp_err_q, resp_err_d;
`endif

   rr_pick #(
      .N  (N_CH),
      .IW (CH_W)
   ) u_rr_pick (
      .pending (pending_q),
      .ptr     (rr_q),
      .valid   (pick_valid),
      .index   (pick_idx)
   );

   always_comb begin
      pending_d     = pending_q;
      overrun_d     = overrun_q;
      cap_mode_d    = cap_mode_q;
      cap_addr_d    = cap_addr_q;
      cap_wdata_d   = cap_wdata_q;
      cap_wstrb_d   = cap_wstrb_q;
      state_d       = state_q;
      grant_d       = grant_q;
      rr_d          = rr_q;
      out_mode_d    = out_mode_q;
      out_addr_d    = out_addr_q;
      out_wdata_d   = out_wdata_q;
      out_wstrb_d   = out_wstrb_q;
      resp_enable_d = '0;
      resp_data_d   = resp_data_q;
      complete      = 1'b0;
`ifdef BUS_TIMEOUT_EN
      wd_d          = wd_q;
      resp_err_d    = 1'b0;
`endif

      // Overrun is judged on the registered pending bit, so a pulse in the
      // cycle the channel's own response arrives is still an overrun.
      for (int i = 0; i < N_CH; i++) begin
         if (req_enable[i]) begin
            if (pending_q[i]) begin
               overrun_d[i] = 1'b1;
            end else begin
               pending_d[i]                     = 1'b1;
               cap_mode_d[i]                    = req_mode[i];
               cap_addr_d[i*ADDR_W +: ADDR_W]   = req_addr[i*ADDR_W +: ADDR_W];
               cap_wdata_d[i*DATA_W +: DATA_W]  = req_wdata[i*DATA_W +: DATA_W];
               cap_wstrb_d[i*STRB_W +: STRB_W]  = req_wstrb[i*STRB_W +: STRB_W];
            end
         end
      end

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_d     = pick_idx;
               out_mode_d  = cap_mode_q[pick_idx];
               out_addr_d  = cap_addr_q[int'(pick_idx)*ADDR_W +: ADDR_W];
               out_wdata_d = cap_wdata_q[int'(pick_idx)*DATA_W +: DATA_W];
               out_wstrb_d = cap_wstrb_q[int'(pick_idx)*STRB_W +: STRB_W];
               state_d     = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            state_d = ARB_WAIT;
`ifdef BUS_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         ARB_WAIT: begin
            if (out_response_enable) begin
               complete    = 1'b1;
               resp_data_d = out_resp_data;
            end
`ifdef BUS_TIMEOUT_EN
            else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               complete    = 1'b1;
               resp_data_d = DATA_W'(TIMEOUT_DATA);
               resp_err_d  = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         default: state_d = ARB_IDLE;
      endcase

      if (complete) begin
         resp_enable_d[grant_q] = 1'b1;
         pending_d[grant_q]     = 1'b0;
         rr_d                   = (int'(grant_q) == N_CH - 1) ? '0 : grant_q + 1'b1;
         state_d                = ARB_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending_q     <= '0;
         overrun_q     <= '0;
         cap_mode_q    <= '0;
         cap_addr_q    <= '0;
         cap_wdata_q   <= '0;
         cap_wstrb_q   <= '0;
         state_q       <= ARB_IDLE;
         grant_q       <= '0;
         rr_q          <= '0;
         out_mode_q    <= BUS_MODE_READ;
         out_addr_q    <= '0;
         out_wdata_q   <= '0;
         out_wstrb_q   <= '0;
         resp_enable_q <= '0;
         resp_data_q   <= '0;
      end else begin
         pending_q     <= pending_d;
         overrun_q     <= overrun_d;
         cap_mode_q    <= cap_mode_d;
         cap_addr_q    <= cap_addr_d;
         cap_wdata_q   <= cap_wdata_d;
         cap_wstrb_q   <= cap_wstrb_d;
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_q          <= rr_d;
         out_mode_q    <= out_mode_d;
         out_addr_q    <= out_addr_d;
         out_wdata_q   <= out_wdata_d;
         out_wstrb_q   <= out_wstrb_d;
         resp_enable_q <= resp_enable_d;
         resp_data_q   <= resp_data_d;
      end
   end

`ifdef BUS_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_q       <= '0;
         resp_err_q <= 1'b0;
      end else begin
         wd_q       <= wd_d;
         resp_err_q <= resp_err_d;
      end
   end
   assign resp_err = resp_err_q;
`else
   assign resp_err = 1'b0;
`endif

   assign resp_enable        = resp_enable_q;
   assign resp_data          = resp_data_q;
   assign out_request_enable = (state_q == ARB_ISSUE);
   assign out_mode           = out_mode_q;
   assign out_addr           = out_addr_q;
   assign out_wdata          = out_wdata_q;
   assign out_wstrb          = out_wstrb_q;
   assign overrun            = overrun_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter (4 channels, TIMEOUT 16); the timeout
// scenario runs only when BUS_TIMEOUT_EN is defined.
module tb_core_bus_arbiter;
   import core_bus_pkg::*;

   localparam int N_CH    = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int STRB_W  = DATA_W / 8;
   localparam int TIMEOUT = 16;

   logic                     clk = 1'b0;
   logic                     rstn = 1'b0;
   logic [N_CH-1:0]          req_enable = '0;
   logic [N_CH-1:0]          req_mode = '0;
   logic [N_CH*ADDR_W-1:0]   req_addr = '0;
   logic [N_CH*DATA_W-1:0]   req_wdata = '0;
   logic [N_CH*STRB_W-1:0]   req_wstrb = '0;
   logic [N_CH-1:0]          resp_enable;
   logic [DATA_W-1:0]        resp_data;
   logic                     resp_err;
   logic                     out_request_enable;
   logic                     out_mode;
   logic [ADDR_W-1:0]        out_addr;
   logic [DATA_W-1:0]        out_wdata;
   logic [STRB_W-1:0]        out_wstrb;
   logic                     out_response_enable = 1'b0;
   logic [DATA_W-1:0]        out_resp_data = '0;
   logic [N_CH-1:0]          overrun;
   logic [1:0]               dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   core_bus_arbiter #(
      .N_CH    (N_CH),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .req_enable          (req_enable),
      .req_mode            (req_mode),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .req_wstrb           (req_wstrb),
      .resp_enable         (resp_enable),
      .resp_data           (resp_data),
      .resp_err            (resp_err),
      .out_request_enable  (out_request_enable),
      .out_mode            (out_mode),
      .out_addr            (out_addr),
      .out_wdata           (out_wdata),
      .out_wstrb           (out_wstrb),
      .out_response_enable (out_response_enable),
      .out_resp_data       (out_resp_data),
      .overrun             (overrun),
      .dbg_state           (dbg_state)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_req(input int ch, input logic mode, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
      req_enable[ch]                  = 1'b1;
      req_mode[ch]                    = mode;
      req_addr[ch*ADDR_W +: ADDR_W]   = addr;
      req_wdata[ch*DATA_W +: DATA_W]  = wdata;
      req_wstrb[ch*STRB_W +: STRB_W]  = wstrb;
   endtask

   task automatic clr_req();
      req_enable = '0;
   endtask

   task automatic apply_reset();
      rstn                = 1'b0;
      req_enable          = '0;
      out_response_enable = 1'b0;
      out_resp_data       = '0;
      step();
      step();
      rstn = 1'b1;
      step();
   endtask

   task automatic wait_issue(output bit ok);
      for (int i = 0; i < 40 && !out_request_enable; i++) step();
      ok = out_request_enable;
   endtask

   // Waits for the next downstream request, checks its fields, answers it
   // 'delay' cycles later and checks the routed response.
   task automatic serve(input int ch, input logic mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] rdata, input int delay);
      bit ok;
      wait_issue(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL issue_ch%0d: out_request_enable=0 after 40 cycles, required 1", ch);
      end
      checks++;
      if ({out_mode, out_addr, out_wdata, out_wstrb} !== {mode, addr, wdata, wstrb}) begin
         errors++;
         $display("FAIL issue_fields_ch%0d: got mode=%0b addr=%h wdata=%h wstrb=%b, required mode=%0b addr=%h wdata=%h wstrb=%b",
                  ch, out_mode, out_addr, out_wdata, out_wstrb, mode, addr, wdata, wstrb);
      end
      step();
      checks++;
      if (out_request_enable !== 1'b0 || dbg_state !== ARB_WAIT) begin
         errors++;
         $display("FAIL issue_one_cycle_ch%0d: got req=%0b state=%0d, required req=0 state=%0d",
                  ch, out_request_enable, dbg_state, ARB_WAIT);
      end
      for (int i = 1; i < delay; i++) step();
      checks++;
      if (out_addr !== addr) begin
         errors++;
         $display("FAIL hold_addr_ch%0d: got %h, required %h", ch, out_addr, addr);
      end
      out_response_enable = 1'b1;
      out_resp_data       = rdata;
      step();
      out_response_enable = 1'b0;
      checks++;
      if (resp_enable !== 4'(1 << ch) || resp_data !== rdata || resp_err !== 1'b0) begin
         errors++;
         $display("FAIL resp_ch%0d: got en=%b data=%h err=%0b, required en=%b data=%h err=0",
                  ch, resp_enable, resp_data, resp_err, 4'(1 << ch), rdata);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (resp_enable !== '0 || resp_data !== '0 || resp_err !== 1'b0 || out_request_enable !== 1'b0 ||
          out_mode !== 1'b0 || out_addr !== '0 || out_wdata !== '0 || out_wstrb !== '0 ||
          overrun !== '0 || dbg_state !== ARB_IDLE) begin
         errors++;
         $display("FAIL reset_outputs: got resp_en=%b data=%h req=%0b addr=%h overrun=%b state=%0d, required all 0",
                  resp_enable, resp_data, out_request_enable, out_addr, overrun, dbg_state);
      end
   endtask

   task automatic test_single_read();
      set_req(0, BUS_MODE_READ, 32'h1000, 32'h0, 4'h0);
      step();
      clr_req();
      checks++;
      if (out_request_enable !== 1'b0) begin
         errors++;
         $display("FAIL single_t1: out_request_enable=%0b one cycle after pulse, required 0", out_request_enable);
      end
      step();
      checks++;
      if (out_request_enable !== 1'b1 || out_addr !== 32'h1000 || out_mode !== 1'b0) begin
         errors++;
         $display("FAIL single_t2: got req=%0b addr=%h mode=%0b, required req=1 addr=00001000 mode=0",
                  out_request_enable, out_addr, out_mode);
      end
      step();
      step();
      step();
      out_response_enable = 1'b1;
      out_resp_data       = 32'hCAFE0001;
      step();
      out_response_enable = 1'b0;
      checks++;
      if (resp_enable !== 4'b0001 || resp_data !== 32'hCAFE0001) begin
         errors++;
         $display("FAIL single_resp: got en=%b data=%h, required en=0001 data=cafe0001", resp_enable, resp_data);
      end
      step();
      checks++;
      if (resp_enable !== 4'b0000 || dbg_state !== ARB_IDLE) begin
         errors++;
         $display("FAIL single_resp_pulse: got en=%b state=%0d, required en=0000 state=0", resp_enable, dbg_state);
      end
   endtask

   task automatic test_two_channels();
      apply_reset();
      set_req(0, BUS_MODE_READ, 32'h0000_0100, 32'h0, 4'h0);
      set_req(1, BUS_MODE_WRITE, 32'h0000_0200, 32'h1234_55AA, 4'b0011);
      step();
      clr_req();
      serve(0, BUS_MODE_READ, 32'h0000_0100, 32'h0, 4'h0, 32'hA0A0_0000, 2);
      serve(1, BUS_MODE_WRITE, 32'h0000_0200, 32'h1234_55AA, 4'b0011, 32'hB0B0_0001, 1);
   endtask

   task automatic test_fairness();
      apply_reset();
      for (int ch = 0; ch < N_CH; ch++) set_req(ch, BUS_MODE_READ, 32'h4000 + 32'(ch * 16), 32'h0, 4'h0);
      step();
      clr_req();
      for (int k = 0; k < 12; k++) begin
         serve(k % N_CH, BUS_MODE_READ, 32'h4000 + 32'((k % N_CH) * 16), 32'h0, 4'h0, 32'h7000 + 32'(k), 1);
         if (k + N_CH < 12) begin
            set_req(k % N_CH, BUS_MODE_READ, 32'h4000 + 32'((k % N_CH) * 16), 32'h0, 4'h0);
            step();
            clr_req();
         end
      end
   endtask

   task automatic test_overrun();
      apply_reset();
      set_req(0, BUS_MODE_READ, 32'h10, 32'h0, 4'h0);
      set_req(1, BUS_MODE_READ, 32'h20, 32'h0, 4'h0);
      step();
      clr_req();
      checks++;
      if (overrun !== 4'b0000) begin
         errors++;
         $display("FAIL overrun_clear: got %b, required 0000", overrun);
      end
      set_req(1, BUS_MODE_WRITE, 32'h24, 32'hFFFF_FFFF, 4'hF);
      step();
      clr_req();
      checks++;
      if (overrun !== 4'b0010) begin
         errors++;
         $display("FAIL overrun_set: got %b, required 0010", overrun);
      end
      serve(0, BUS_MODE_READ, 32'h10, 32'h0, 4'h0, 32'h1111_0000, 2);
      serve(1, BUS_MODE_READ, 32'h20, 32'h0, 4'h0, 32'h2222_0000, 2);
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_request_enable !== 1'b0) begin
            errors++;
            $display("FAIL overrun_no_reissue: out_request_enable=%0b %0d cycles after response, required 0", out_request_enable, i + 1);
         end
      end
      checks++;
      if (overrun !== 4'b0010) begin
         errors++;
         $display("FAIL overrun_sticky: got %b, required 0010", overrun);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      apply_reset();
      set_req(0, BUS_MODE_READ, 32'h300, 32'h0, 4'h0);
      step();
      clr_req();
      wait_issue(ok);
      step();
      checks++;
      if (!ok || dbg_state !== ARB_WAIT) begin
         errors++;
         $display("FAIL midwait_enter: got issued=%0b state=%0d, required issued=1 state=%0d", ok, dbg_state, ARB_WAIT);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (out_request_enable !== 1'b0 || out_addr !== '0 || resp_enable !== '0 || dbg_state !== ARB_IDLE) begin
         errors++;
         $display("FAIL midwait_async_reset: got req=%0b addr=%h resp_en=%b state=%0d, required all 0",
                  out_request_enable, out_addr, resp_enable, dbg_state);
      end
      step();
      rstn = 1'b1;
      step();
      out_response_enable = 1'b1;
      out_resp_data       = 32'h9999_9999;
      step();
      out_response_enable = 1'b0;
      checks++;
      if (resp_enable !== '0 || resp_data !== '0 || out_request_enable !== 1'b0 || dbg_state !== ARB_IDLE) begin
         errors++;
         $display("FAIL midwait_late_resp: got en=%b data=%h req=%0b state=%0d, required all 0",
                  resp_enable, resp_data, out_request_enable, dbg_state);
      end
      set_req(1, BUS_MODE_WRITE, 32'h400, 32'hABCD_0123, 4'b1010);
      step();
      clr_req();
      serve(1, BUS_MODE_WRITE, 32'h400, 32'hABCD_0123, 4'b1010, 32'h5555_AAAA, 3);
   endtask

`ifdef BUS_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      apply_reset();
      set_req(2, BUS_MODE_READ, 32'h500, 32'h0, 4'h0);
      step();
      clr_req();
      wait_issue(ok);
      for (int i = 0; i < TIMEOUT; i++) step();
      checks++;
      if (!ok || resp_enable !== '0) begin
         errors++;
         $display("FAIL timeout_early: got issued=%0b en=%b after %0d WAIT cycles, required issued=1 en=0000", ok, resp_enable, TIMEOUT - 1);
      end
      step();
      checks++;
      if (resp_enable !== 4'b0100 || resp_err !== 1'b1 || resp_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL timeout_resp: got en=%b err=%0b data=%h, required en=0100 err=1 data=deadbeef",
                  resp_enable, resp_err, resp_data);
      end
      step();
      out_response_enable = 1'b1;
      out_resp_data       = 32'h1234_5678;
      step();
      out_response_enable = 1'b0;
      checks++;
      if (resp_enable !== '0 || resp_err !== 1'b0 || dbg_state !== ARB_IDLE) begin
         errors++;
         $display("FAIL timeout_late_resp: got en=%b err=%0b state=%0d, required en=0000 err=0 state=0",
                  resp_enable, resp_err, dbg_state);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded 200000 time units");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      test_reset();
      test_single_read();
      test_two_channels();
      test_fairness();
      test_overrun();
      test_reset_mid_wait();
`ifdef BUS_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
